// File: rtl/pp_accumulator.sv
// Shift-and-add reducer for an N*N AND-array partial-product vector.
// It adds one row per cycle and holds the 2N-bit product under a valid/ready handshake.
module pp_accumulator #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*N-1:0] pp_in,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*N-1:0] product,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [N*N-1:0]   pp_r;
    logic [CW-1:0]    cnt_r;
    logic [2*N-1:0]   acc_r;
    logic [2*N-1:0]   product_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [2*N-1:0]   row_term_s;
    logic [2*N-1:0]   acc_sum_s;
    logic             last_row_s;

    // Row weight equals its A-bit index, so the shift amount is the row counter.
    assign row_term_s = {{N{1'b0}}, pp_r[cnt_r*N +: N]} << cnt_r;
    assign acc_sum_s  = acc_r + row_term_s;
    assign last_row_s = (cnt_r == CW'(N - 1));

    assign in_ready  = (state_r == IDLE);
    assign product   = product_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_next_s = ACCUM;
                else          state_next_s = IDLE;
            end
            ACCUM: begin
                if (last_row_s) state_next_s = DONE;
                else            state_next_s = ACCUM;
            end
            DONE: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Capture, accumulate and result hold; the final row's sum goes straight to product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_r        <= '0;
            cnt_r       <= '0;
            acc_r       <= '0;
            product_r   <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        pp_r  <= pp_in;
                        acc_r <= '0;
                        cnt_r <= '0;
                    end
                end
                ACCUM: begin
                    acc_r <= acc_sum_s;
                    if (last_row_s) begin
                        product_r   <= acc_sum_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_r <= 1'b0;
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed self-checking bench for pp_accumulator (N=4).
// Expected products are hand-computed: sum of row_i << i over the 4-bit rows.
module tb_pp_accumulator;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N*N-1:0] pp_in;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] product;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    int tests_run;
    int tests_failed;
    int cyc;
    logic mon_en;
    logic [2*N-1:0] got_q[$];

    pp_accumulator #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pp_in     (pp_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mon_en && rst_n && out_valid && out_ready) got_q.push_back(product);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction; latency counts edges after the accept edge until out_valid.
    task automatic do_op(input string tag, input logic [15:0] v, input logic [7:0] exp);
        int edges;
        @(negedge clk);
        pp_in    = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pp_in    = 16'h5A5A;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_lat"}, edges, N);
        check({tag, "_prod"}, {24'd0, product}, {24'd0, exp});
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_ovdrop"}, {31'd0, out_valid}, 32'd0);
            check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [15:0] vals[3];
        logic [7:0]  exps[3];
        int          acc_cyc[3];
        int          guard;

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        mon_en       = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        pp_in        = 16'h0000;
        out_ready    = 1'b1;

        #1;
        check("rst_prod", {24'd0, product}, 32'd0);
        check("rst_ov", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 13 x 11
        do_op("a13b11", 16'hBB0B, 8'h8F);
        do_op("ones", 16'hFFFF, 8'hE1);
        do_op("zero", 16'h0000, 8'h00);

        // Backpressure with a competing input that must not be captured.
        out_ready = 1'b0;
        do_op("bp", 16'hBB0B, 8'h8F);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            pp_in    = 16'hFFFF;
            @(posedge clk);
            #1;
            check("bp_hold_prod", {24'd0, product}, 32'h8F);
            check("bp_hold_ov", {31'd0, out_valid}, 32'd1);
            check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel_ov", {31'd0, out_valid}, 32'd0);
        check("bp_rel_prod", {24'd0, product}, 32'h8F);
        check("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp_no_capture", {31'd0, busy}, 32'd0);

        // Asynchronous reset while the row counter is at 2.
        @(negedge clk);
        pp_in    = 16'hBB0B;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_prod", {24'd0, product}, 32'd0);
        check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 16'hBB0B, 8'h8F);

        // Back-to-back stream with in_valid held high.
        vals[0] = 16'hBB0B; exps[0] = 8'd143;
        vals[1] = 16'h0001; exps[1] = 8'd1;
        vals[2] = 16'h8000; exps[2] = 8'd64;
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            pp_in    = vals[k];
            in_valid = 1'b1;
            guard    = 0;
            while (!in_ready && guard < 30) begin
                @(negedge clk);
                guard++;
            end
            check("b2b_accept_timeout", (guard < 30) ? 32'd1 : 32'd0, 32'd1);
            @(posedge clk);
            #1;
            acc_cyc[k] = cyc;
        end
        in_valid = 1'b0;
        guard    = 0;
        while (got_q.size() < 3 && guard < 30) begin
            @(posedge clk);
            guard++;
        end
        repeat (8) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("b2b_count", got_q.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got_q.size()) check($sformatf("b2b_prod%0d", k), {24'd0, got_q[k]}, {24'd0, exps[k]});
            else                  check($sformatf("b2b_missing%0d", k), 32'd0, 32'd1);
        end
        check("b2b_gap01", acc_cyc[1] - acc_cyc[0], N + 2);
        check("b2b_gap12", acc_cyc[2] - acc_cyc[1], N + 2);

        // Non rank-1 vector: bits 0 and 4 -> 1 + 2.
        do_op("nonrank1", 16'h0011, 8'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
